// File: rtl/pixel_sink.sv
// Pixel sink: deserializes bit-serial pixel words from the rasterizer and queues
// framebuffer writes through a small FIFO, with per-triangle completion tracking.
module pixel_sink #(
  parameter int unsigned WIDTH      = 320,
  parameter int unsigned HEIGHT     = 240,
  parameter int unsigned ADDR_W     = 17,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              PX_S,
  input  logic              PY_S,
  input  logic              C_S,
  input  logic              WSTART,
  input  logic              PVALID,
  input  logic              TRI_DONE,
  input  logic              FB_READY,
  output logic              FB_WE,
  output logic [ADDR_W-1:0] FB_ADDR,
  output logic [15:0]       FB_DATA,
  output logic              TRI_DONE_OUT,
  output logic [15:0]       PIX_CNT,
  output logic [7:0]        DROP_CNT,
  output logic              ERR
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned ENT_W = ADDR_W + 16;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t      state_reg;
  logic [3:0]  bit_cnt_reg;
  logic [14:0] x_sr_reg;
  logic [14:0] y_sr_reg;
  logic [14:0] c_sr_reg;
  logic        pvalid_reg;
  logic        pending_reg;
  logic [15:0] pix_cnt_reg;
  logic [7:0]  drop_cnt_reg;
  logic        err_reg;

  logic [ENT_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;

  logic              word_done;
  logic [15:0]       x_word;
  logic [15:0]       y_word;
  logic [15:0]       c_word;
  logic              in_range;
  logic [ADDR_W-1:0] addr_full;
  logic              push_req;
  logic              push_ok;
  logic              pop;
  logic              drop;
  logic              fifo_empty;
  logic              fifo_full;
  logic              tri_done_out;
  logic [ENT_W-1:0]  head;

  // The 16th bit is taken straight off the serial lines so the push happens on
  // the very edge that samples it.
  assign word_done = (state_reg == SHIFT) && !WSTART && (bit_cnt_reg == 4'd15);
  assign x_word    = {x_sr_reg, PX_S};
  assign y_word    = {y_sr_reg, PY_S};
  assign c_word    = {c_sr_reg, C_S};
  assign in_range  = (32'(x_word) < WIDTH) && (32'(y_word) < HEIGHT);
  assign addr_full = ADDR_W'(32'(y_word) * WIDTH + 32'(x_word));
  assign push_req  = word_done && pvalid_reg && in_range;

  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == (PTR_W+1)'(FIFO_DEPTH));
  assign pop        = !fifo_empty && FB_READY;
  assign push_ok    = push_req && (!fifo_full || pop);
  assign drop       = push_req && fifo_full && !pop;

  // A word in flight or queued writes keep the completion pulse back.
  assign tri_done_out = pending_reg && (state_reg == IDLE) && fifo_empty;

  assign head         = mem[rd_ptr_reg];
  assign FB_WE        = !fifo_empty;
  assign FB_ADDR      = FB_WE ? head[ENT_W-1:16] : '0;
  assign FB_DATA      = FB_WE ? head[15:0] : 16'h0000;
  assign TRI_DONE_OUT = tri_done_out;
  assign PIX_CNT      = pix_cnt_reg;
  assign DROP_CNT     = drop_cnt_reg;
  assign ERR          = err_reg;

  always_ff @(posedge CLK) begin
    if (push_ok)
      mem[wr_ptr_reg] <= {addr_full, c_word};
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg    <= IDLE;
      bit_cnt_reg  <= 4'd0;
      x_sr_reg     <= '0;
      y_sr_reg     <= '0;
      c_sr_reg     <= '0;
      pvalid_reg   <= 1'b0;
      pending_reg  <= 1'b0;
      pix_cnt_reg  <= 16'd0;
      drop_cnt_reg <= 8'd0;
      err_reg      <= 1'b0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
    end else begin
      // WSTART always (re)starts a word; mid-word it flags a framing error.
      if (WSTART) begin
        if (state_reg == SHIFT)
          err_reg <= 1'b1;
        state_reg   <= SHIFT;
        bit_cnt_reg <= 4'd1;
        pvalid_reg  <= PVALID;
        x_sr_reg    <= {14'd0, PX_S};
        y_sr_reg    <= {14'd0, PY_S};
        c_sr_reg    <= {14'd0, C_S};
      end else if (state_reg == SHIFT) begin
        x_sr_reg <= {x_sr_reg[13:0], PX_S};
        y_sr_reg <= {y_sr_reg[13:0], PY_S};
        c_sr_reg <= {c_sr_reg[13:0], C_S};
        if (bit_cnt_reg == 4'd15) begin
          state_reg   <= IDLE;
          bit_cnt_reg <= 4'd0;
        end else begin
          bit_cnt_reg <= bit_cnt_reg + 4'd1;
        end
      end

      if (push_ok)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (push_ok && !pop)
        count_reg <= count_reg + 1'b1;
      else if (!push_ok && pop)
        count_reg <= count_reg - 1'b1;

      if (drop && (drop_cnt_reg != 8'hFF))
        drop_cnt_reg <= drop_cnt_reg + 8'd1;

      if (tri_done_out)
        pending_reg <= 1'b0;
      else if (TRI_DONE)
        pending_reg <= 1'b1;

      if (tri_done_out)
        pix_cnt_reg <= {15'd0, pop};
      else if (pop)
        pix_cnt_reg <= pix_cnt_reg + 16'd1;
    end
  end

endmodule
